preg_freelist: RTL and testbench

- Circular-FIFO free list of physical register IDs.
- Replaces the counter allocator in the rename stage, so pregs can be released out of allocation order.
- Rename pops one preg per renamed instruction that has rd_valid. Commit pushes back the preg of each retired entry with needprf2arf set.
- After reset or squash, an init FSM refills the list with every preg ID.

---
 rtl/preg_freelist_pkg.sv | 15 +
 rtl/fl_fifo_mem.sv | 33 +++
 rtl/preg_freelist.sv | 137 +++++++++++++
 tb/tb_preg_freelist.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/preg_freelist_pkg.sv
// Shared rename-stage constants and types for the physical register free list.
package preg_freelist_pkg;

  localparam int unsigned PRFSIZE      = 64;
  localparam int unsigned PREG_ID_BITS = 6;

  typedef logic [PREG_ID_BITS-1:0] preg_id_t;

  // Free list controller phases: refill after reset/squash, then normal operation.
  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } freelist_state_e;

endpackage

// File: rtl/fl_fifo_mem.sv
// Free list storage: one async read port (FIFO head), one sync write port (FIFO tail).
// The write data is selected between the refill counter and the committed preg.
module fl_fifo_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ID_W  = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic            init_sel,
  input  logic [ID_W-1:0] init_data,
  input  logic [ID_W-1:0] free_data,
  input  logic [ID_W-1:0] waddr,
  input  logic [ID_W-1:0] raddr,
  output logic [ID_W-1:0] rdata
);

  logic [ID_W-1:0] mem [DEPTH];
  logic [ID_W-1:0] wdata;

  // Refill writes the counter value; otherwise the released preg.
  always_comb begin
    wdata = free_data;
    if (init_sel) wdata = init_data;
  end

  // Synchronous write at the tail.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/preg_freelist.sv
// Circular-FIFO free list of physical register IDs for the rename stage.
// Rename pops from the head, commit pushes to the tail, so pregs may return
// out of allocation order. After reset or squash the list is refilled with
// every preg ID, one per cycle.
// Optional macro PREG_FREELIST_CHECK_EN adds a per-preg bitmap that drops
// duplicate frees and flags them on double_free_o.
module preg_freelist
  import preg_freelist_pkg::*;
#(
  parameter int unsigned NUM_PREGS = PRFSIZE,
  parameter int unsigned ID_W      = PREG_ID_BITS
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alloc_req_i,
  output logic            alloc_ready_o,
  output logic [ID_W-1:0] alloc_preg_o,
  input  logic            free_valid_i,
  input  logic [ID_W-1:0] free_preg_i,
  input  logic            squash_i,
  output logic            busy_o,
  output logic [ID_W:0]   count_o,
  output logic            double_free_o
);

  localparam int unsigned CNT_W = ID_W + 1;

  freelist_state_e state;
  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  tail;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  init_ctr;
  logic             double_free_q;

  logic run;
  logic not_empty;
  logic full;
  logic dup;
  logic alloc_fire;
  logic free_err;
  logic free_fire;
  logic mem_we;

  // Handshake and error decode from current state; squash blocks all updates.
  always_comb begin
    run        = (state == FL_RUN);
    not_empty  = (count != '0);
    full       = (count == CNT_W'(NUM_PREGS));
    alloc_fire = run && alloc_req_i && not_empty;
    free_err   = run && free_valid_i && (full || dup);
    free_fire  = run && free_valid_i && !free_err;
    mem_we     = !squash_i && ((state == FL_INIT) || free_fire);
  end

  fl_fifo_mem #(
    .DEPTH (NUM_PREGS),
    .ID_W  (ID_W)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .init_sel  (state == FL_INIT),
    .init_data (init_ctr),
    .free_data (free_preg_i),
    .waddr     (tail),
    .raddr     (head),
    .rdata     (alloc_preg_o)
  );

  // Controller: refill sequencing, pointer/count bookkeeping, error pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= FL_INIT;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      init_ctr      <= '0;
      double_free_q <= 1'b0;
    end else if (squash_i) begin
      state         <= FL_INIT;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      init_ctr      <= '0;
      double_free_q <= 1'b0;
    end else begin
      double_free_q <= free_err;
      case (state)
        FL_INIT: begin
          tail     <= tail + ID_W'(1);
          count    <= count + CNT_W'(1);
          init_ctr <= init_ctr + ID_W'(1);
          if (init_ctr == ID_W'(NUM_PREGS - 1)) state <= FL_RUN;
        end
        default: begin
          if (alloc_fire) head <= head + ID_W'(1);
          if (free_fire)  tail <= tail + ID_W'(1);
          case ({alloc_fire, free_fire})
            2'b10:   count <= count - CNT_W'(1);
            2'b01:   count <= count + CNT_W'(1);
            default: count <= count;
          endcase
        end
      endcase
    end
  end

`ifdef PREG_FREELIST_CHECK_EN
  logic [NUM_PREGS-1:0] free_map;

  assign dup = free_map[free_preg_i];

  // Bitmap of pregs currently held in the list.
  always_ff @(posedge clk) begin
    if (!rstn || squash_i) begin
      free_map <= '0;
    end else if (state == FL_INIT) begin
      free_map[init_ctr] <= 1'b1;
    end else begin
      if (alloc_fire) free_map[head] <= 1'b0;
      if (free_fire)  free_map[free_preg_i] <= 1'b1;
    end
  end

  // The head entry offered to rename must be marked free.
  always_ff @(posedge clk) begin
    if (rstn && run && not_empty) assert (free_map[alloc_preg_o]);
  end
`else
  assign dup = 1'b0;
`endif

  assign alloc_ready_o = run && not_empty;
  assign busy_o        = (state == FL_INIT);
  assign count_o       = count;
  assign double_free_o = double_free_q;

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed scenarios followed by a
// randomized phase, all compared against a queue-based model of the free list.
module tb_preg_freelist;
  import preg_freelist_pkg::*;

  localparam int unsigned NUM  = PRFSIZE;
  localparam int unsigned ID_W = PREG_ID_BITS;

  logic            clk = 1'b0;
  logic            rstn;
  logic            alloc_req_i;
  logic            alloc_ready_o;
  logic [ID_W-1:0] alloc_preg_o;
  logic            free_valid_i;
  logic [ID_W-1:0] free_preg_i;
  logic            squash_i;
  logic            busy_o;
  logic [ID_W:0]   count_o;
  logic            double_free_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the list contents as a queue, refill cycles remaining, error pulse.
  int q[$];
  int init_left = 0;
  bit dfree = 1'b0;

  preg_freelist dut (
    .clk           (clk),
    .rstn          (rstn),
    .alloc_req_i   (alloc_req_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_preg_o  (alloc_preg_o),
    .free_valid_i  (free_valid_i),
    .free_preg_i   (free_preg_i),
    .squash_i      (squash_i),
    .busy_o        (busy_o),
    .count_o       (count_o),
    .double_free_o (double_free_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_list(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge(input bit rst, input bit req, input bit fv, input int fp, input bit sq);
    bit a;
    bit err;
    bit dup;
    if (rst || sq) begin
      q.delete();
      init_left = NUM;
      dfree = 1'b0;
    end else if (init_left > 0) begin
      q.push_back(NUM - init_left);
      init_left--;
      dfree = 1'b0;
    end else begin
`ifdef PREG_FREELIST_CHECK_EN
      dup = in_list(fp);
`else
      dup = 1'b0;
`endif
      a   = req && (q.size() != 0);
      err = fv && ((q.size() == NUM) || dup);
      if (a) void'(q.pop_front());
      if (fv && !err) q.push_back(fp);
      dfree = err;
    end
  endtask

  task automatic check_all(input string tag);
    bit busy_e;
    bit rdy_e;
    busy_e = (init_left > 0);
    rdy_e  = !busy_e && (q.size() != 0);
    chk({tag, ".busy"},  32'(busy_o),        32'(busy_e));
    chk({tag, ".ready"}, 32'(alloc_ready_o), 32'(rdy_e));
    chk({tag, ".count"}, 32'(count_o),       32'(q.size()));
    chk({tag, ".dfree"}, 32'(double_free_o), 32'(dfree));
    if (rdy_e) chk({tag, ".preg"}, 32'(alloc_preg_o), 32'(q[0]));
  endtask

  // One clock: drive inputs, take the edge, update model, sample 1 time unit later.
  task automatic cyc(input string tag, input bit rb, input bit req, input bit fv,
                     input int fp, input bit sq);
    rstn         = rb;
    alloc_req_i  = req;
    free_valid_i = fv;
    free_preg_i  = ID_W'(fp);
    squash_i     = sq;
    @(posedge clk);
    model_edge(!rb, req, fv, fp, sq);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; alloc_req_i = 1'b0; free_valid_i = 1'b0; free_preg_i = '0; squash_i = 1'b0;

    // Reset state
    cyc("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("reset", 1'b0, 1'b1, 1'b1, 9, 1'b0);
    chk("reset_busy", 32'(busy_o), 32'd1);
    chk("reset_count", 32'(count_o), 32'd0);

    // Refill: busy for exactly NUM cycles
    idle("init", NUM - 1);
    chk("init_last_busy", 32'(busy_o), 32'd1);
    idle("init", 1);
    chk("init_done_busy", 32'(busy_o), 32'd0);
    chk("init_done_count", 32'(count_o), 32'(NUM));
    chk("init_done_preg", 32'(alloc_preg_o), 32'd0);

    // Drain in order 0..NUM-1
    for (int i = 0; i < NUM; i++) begin
      chk("drain_preg", 32'(alloc_preg_o), 32'(i));
      cyc("drain", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    end
    chk("drain_ready", 32'(alloc_ready_o), 32'd0);
    chk("drain_count", 32'(count_o), 32'd0);

    // Out-of-order release: free 7 then 3 (the first with a blocked alloc), then pop both
    cyc("ooo", 1'b1, 1'b1, 1'b1, 7, 1'b0);
    chk("ooo_nobypass_count", 32'(count_o), 32'd1);
    cyc("ooo", 1'b1, 1'b0, 1'b1, 3, 1'b0);
    chk("ooo_first", 32'(alloc_preg_o), 32'd7);
    cyc("ooo", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("ooo_second", 32'(alloc_preg_o), 32'd3);
    cyc("ooo", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("ooo_empty", 32'(count_o), 32'd0);

    // Fill to 10, then steady alloc+free for 20 cycles
    for (int i = 0; i < 10; i++) cyc("fill", 1'b1, 1'b0, 1'b1, 20 + i, 1'b0);
    for (int i = 0; i < 20; i++) cyc("steady", 1'b1, 1'b1, 1'b1, 40 + i, 1'b0);
    chk("steady_count", 32'(count_o), 32'd10);

    // Squash in RUN with count 5, then squash again mid-refill
    for (int i = 0; i < 5; i++) cyc("pre_squash", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("pre_squash_count", 32'(count_o), 32'd5);
    cyc("squash", 1'b1, 1'b1, 1'b1, 1, 1'b1);
    chk("squash_busy", 32'(busy_o), 32'd1);
    chk("squash_ready", 32'(alloc_ready_o), 32'd0);
    idle("refill", 29);
    cyc("squash2", 1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("squash2_count", 32'(count_o), 32'd0);
    idle("refill2", NUM);
    chk("refill2_count", 32'(count_o), 32'(NUM));
    chk("refill2_preg", 32'(alloc_preg_o), 32'd0);

    // Free while full: dropped, one-cycle error pulse
    cyc("full_free", 1'b1, 1'b0, 1'b1, 12, 1'b0);
    chk("full_free_pulse", 32'(double_free_o), 32'd1);
    chk("full_free_count", 32'(count_o), 32'(NUM));
    idle("full_free_after", 1);
    chk("full_free_pulse_end", 32'(double_free_o), 32'd0);

`ifdef PREG_FREELIST_CHECK_EN
    // Duplicate free of a preg already in the list
    for (int i = 0; i < 14; i++) cyc("dup_prep", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cyc("dup1", 1'b1, 1'b0, 1'b1, 5, 1'b0);
    chk("dup1_count", 32'(count_o), 32'd51);
    cyc("dup2", 1'b1, 1'b0, 1'b1, 5, 1'b0);
    chk("dup2_pulse", 32'(double_free_o), 32'd1);
    chk("dup2_count", 32'(count_o), 32'd51);
`endif

    // Randomized traffic with occasional squash
    for (int i = 0; i < 1500; i++) begin
      bit req;
      bit fv;
      bit sq;
      int fp;
      req = ($urandom_range(0, 3) != 0);
      fv  = ($urandom_range(0, 2) != 0);
      sq  = ($urandom_range(0, 199) == 0);
`ifdef PREG_FREELIST_CHECK_EN
      fp  = ($urandom_range(0, 3) == 0 && q.size() != 0) ? q[0] : int'($urandom_range(0, NUM - 1));
`else
      fp  = int'($urandom_range(0, NUM - 1));
`endif
      cyc("rand", 1'b1, req, fv, fp, sq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
